// File: rtl/key_event_scheduler.sv
// key_event_scheduler
// Collects one-cycle key press strobes into per-key pending flags and
// presents them one at a time as events on a valid/ready interface.
// A round-robin pointer picks the next pending key, and an optional idle
// gap can be enforced after every accepted event.
//
// Parameters:
//   KEYS_NUM       number of key strobe inputs (2..32)
//   GAP_CYCLES     idle cycles forced after each accepted event (0..65535)
//   DROP_CNT_WIDTH width of the drop counter
//   CODE_W         derived: max(1, $clog2(KEYS_NUM))
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   key_stb_i    per-key one-cycle press strobes
//   evt_valid_o  event available (registered, no path from evt_ready_i)
//   evt_ready_i  consumer accepts the presented event
//   evt_code_o   key index of the presented event
//   pending_o    per-key pending flags
//   drop_cnt_o   saturating count of cycles with lost strobes
//
// Build option: define KEY_EVT_DROP_CNT_EN to include the drop counter;
// without it drop_cnt_o is tied to zero.
module key_event_scheduler #(
  parameter int unsigned KEYS_NUM       = 4,
  parameter int unsigned GAP_CYCLES     = 0,
  parameter int unsigned DROP_CNT_WIDTH = 8,
  localparam int unsigned CODE_W        = (KEYS_NUM > 1) ? $clog2(KEYS_NUM) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [KEYS_NUM-1:0]       key_stb_i,
  output logic                      evt_valid_o,
  input  logic                      evt_ready_i,
  output logic [CODE_W-1:0]         evt_code_o,
  output logic [KEYS_NUM-1:0]       pending_o,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_VALID, S_GAP} state_e;

  state_e              state_q, state_d;
  logic [KEYS_NUM-1:0] pending_q, pending_d;
  logic [CODE_W-1:0]   ptr_q, ptr_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [15:0]         gap_q, gap_d;

  logic                grant_hit;
  logic                grant_en;
  logic [CODE_W-1:0]   grant_code;
  logic [CODE_W-1:0]   rr_sel;
  logic [KEYS_NUM-1:0] grant_mask;
  int unsigned         rr_idx;

  // Round-robin search: visit ptr, ptr+1, ... wrapping at KEYS_NUM-1.
  // ptr is always < KEYS_NUM, so one conditional subtraction wraps the sum.
  always_comb begin
    grant_hit  = 1'b0;
    grant_code = '0;
    rr_idx     = 0;
    rr_sel     = '0;
    for (int unsigned i = 0; i < KEYS_NUM; i++) begin
      rr_idx = 32'(ptr_q) + i;
      if (rr_idx >= KEYS_NUM) rr_idx = rr_idx - KEYS_NUM;
      rr_sel = CODE_W'(rr_idx);
      if (!grant_hit && pending_q[rr_sel]) begin
        grant_hit  = 1'b1;
        grant_code = rr_sel;
      end
    end
  end

  always_comb begin
    grant_en   = (state_q == S_IDLE) && grant_hit;
    grant_mask = '0;
    if (grant_en) grant_mask[grant_code] = 1'b1;
  end

  // Clearing the granted bit before OR-ing in new strobes lets a strobe on
  // the key being granted re-arm it for a later event.
  always_comb begin
    state_d   = state_q;
    pending_d = (pending_q & ~grant_mask) | key_stb_i;
    ptr_d     = ptr_q;
    code_d    = code_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          code_d  = grant_code;
          ptr_d   = (grant_code == CODE_W'(KEYS_NUM - 1)) ? '0 : grant_code + 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (evt_ready_i) begin
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = 16'(GAP_CYCLES);
          end
        end
      end
      S_GAP: begin
        if (gap_q <= 16'd1) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      ptr_q     <= '0;
      code_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      code_q    <= code_d;
      gap_q     <= gap_d;
    end
  end

  assign evt_valid_o = (state_q == S_VALID);
  assign evt_code_o  = code_q;
  assign pending_o   = pending_q;

`ifdef KEY_EVT_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic                      drop_hit;

  // A strobe is lost when its key is already pending and not being granted.
  always_comb begin
    drop_hit = |(key_stb_i & pending_q & ~grant_mask);
    drop_d   = drop_q;
    if (drop_hit && (drop_q != '1)) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_cnt_o = drop_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: doc/key_event_scheduler.md
KEY_EVENT_SCHEDULER -- requirements
Module: key_event_scheduler

Interface
REQ-001 Parameter KEYS_NUM, default 4, number of debounced key strobe inputs (legal 2..32).
REQ-002 Parameter GAP_CYCLES, default 0, minimum idle cycles after each accepted event (legal 0..65535).
REQ-003 Parameter DROP_CNT_WIDTH, default 8, width of the drop counter.
REQ-004 Derived CODE_W SHALL equal max(1, $clog2(KEYS_NUM)).
REQ-005 clk_i  input  1  single clock; all logic on rising edge.
REQ-006 rst_i  input  1  synchronous, active-high reset.
REQ-007 key_stb_i  input  KEYS_NUM  one-cycle press strobes, one bit per key debouncer key_pressed_stb_o.
REQ-008 evt_valid_o  output  1  event available.
REQ-009 evt_ready_i  input  1  consumer accepts event.
REQ-010 evt_code_o  output  CODE_W  index of the key for the presented event.
REQ-011 pending_o  output  KEYS_NUM  per-key pending flags.
REQ-012 drop_cnt_o  output  DROP_CNT_WIDTH  count of lost strobes (see REQ-030).

Function
REQ-013 key_stb_i[k]=1 in cycle N SHALL set pending[k], visible on pending_o in N+1.
REQ-014 FSM states: IDLE, VALID, GAP.
REQ-015 IDLE: if any pending bit is set, grant one key round-robin, load evt_code_o, clear that pending bit, enter VALID. With no pending bits set, remain in IDLE.
REQ-016 Round-robin search SHALL start at pointer ptr, go upward and wrap at KEYS_NUM-1 to 0; after grant g, ptr SHALL become (g+1) mod KEYS_NUM.
REQ-017 Latency: a strobe in cycle N into an idle, empty block SHALL raise evt_valid_o in cycle N+2.
REQ-018 VALID: evt_valid_o=1; evt_code_o SHALL stay stable until a handshake (evt_valid_o & evt_ready_i).
REQ-019 On handshake: if GAP_CYCLES=0, go to IDLE; otherwise go to GAP with counter loaded to GAP_CYCLES.
REQ-020 GAP: evt_valid_o=0; decrement each cycle; go to IDLE when the counter reaches 1.
REQ-021 With GAP_CYCLES=G, handshake in cycle M SHALL give the next evt_valid_o no earlier than cycle M+2+G.
REQ-022 A strobe on key k while pending[k]=1 and k is not granted that cycle SHALL count as a drop; pending[k] SHALL stay 1.
REQ-023 A strobe on key k in the same cycle k is granted SHALL leave pending[k]=1 and SHALL NOT count as a drop.
REQ-024 A strobe on the key currently shown in VALID SHALL set pending for a later event, not a drop.
REQ-025 Simultaneous strobes on several keys SHALL all set pending; service order follows REQ-016.
REQ-026 evt_valid_o SHALL only change on a clock edge; evt_ready_i SHALL have no combinational path to any output.

Reset
REQ-027 While rst_i=1 at an edge: state=IDLE, pending=0, ptr=0, evt_valid_o=0, evt_code_o=0, GAP counter=0, drop_cnt_o=0.
REQ-028 key_stb_i asserted in a reset cycle SHALL be ignored.
REQ-029 Reset in VALID or GAP SHALL abort the event; the pending event is lost and evt_valid_o=0 in the next cycle.

Configuration
REQ-030 With KEY_EVT_DROP_CNT_EN defined: drop_cnt_o increments by 1 in each cycle containing one or more drops, saturating at all-ones.
REQ-031 Without KEY_EVT_DROP_CNT_EN: no counter logic; drop_cnt_o SHALL be constant 0. All other behaviour is identical.

Verification
REQ-032 KEYS_NUM=4, GAP=0, ready=1: stb on key 2 at cycle 10 -> valid=1, code=2 at cycle 12 only; pending_o=0 by cycle 12.
REQ-033 key_stb_i=4'b1111 in one cycle, ptr=0, ready=1 -> codes 0,1,2,3 in order, valids at cycles N+2, N+4, N+6, N+8.
REQ-034 ready=0 for 20 cycles during VALID -> code stable, valid held; 3 further stbs on the same non-shown key -> drop_cnt_o=2 (macro on), 0 (macro off).
REQ-035 GAP_CYCLES=5: handshake at cycle M with another key pending -> next valid at M+7.
REQ-036 rst_i=1 for one cycle in VALID with pending=4'b0110 -> all outputs 0 next cycle; stb on key 3 during reset produces no event.
REQ-037 DROP_CNT_WIDTH=2, macro on, 5 drop cycles -> drop_cnt_o saturates at 3.
